// File: rtl/pattern_gen.sv
// Serial frame generator: shifts out up to DATA_W frame bits MSB first, with an optional
// 0,1,1,0,1 tail, under valid/ready handshake, and counts overlapping 01101 patterns per frame.
module pattern_gen #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8,
  localparam int LEN_W = $clog2(DATA_W) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              inject_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              d_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  pattern_cnt_o
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SEND = 4'b0010,
    TAIL = 4'b0100,
    DONE = 4'b1000
  } state_t;

  localparam logic [4:0]       PATTERN = 5'b01101;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [LEN_W-1:0]    bits_left_q, bits_left_d;
  logic                inject_q, inject_d;
  logic [2:0]          tail_idx_q, tail_idx_d;
  logic [4:0]          hist_q, hist_d;
  logic [2:0]          sent_q, sent_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_eff;
  logic                bit_cur;
  logic                xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign len_eff = (len_i > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len_i;

  always_comb begin
    bit_cur = 1'b0;
    case (state_q)
      SEND:    bit_cur = shreg_q[DATA_W-1];
      TAIL:    bit_cur = PATTERN[3'd4 - tail_idx_q];
      default: bit_cur = 1'b0;
    endcase
  end

  assign valid_o       = (state_q == SEND) || (state_q == TAIL);
  assign busy_o        = valid_o;
  assign done_o        = (state_q == DONE);
  assign d_o           = bit_cur;
  assign pattern_cnt_o = cnt_q;
  assign xfer          = valid_o && ready_i;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    inject_d    = inject_q;
    tail_idx_d  = tail_idx_q;
    hist_d      = hist_q;
    sent_d      = sent_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d     = data_i;
          bits_left_d = len_eff;
          inject_d    = inject_i;
          tail_idx_d  = 3'd0;
          hist_d      = 5'd0;
          sent_d      = 3'd0;
          cnt_d       = '0;
          if (len_eff != '0)  state_d = SEND;
          else if (inject_i)  state_d = TAIL;
          else                state_d = DONE;
        end
      end
      SEND: begin
        if (xfer) begin
          shreg_d     = shreg_q << 1;
          bits_left_d = bits_left_q - 1'b1;
          if (bits_left_q == LEN_W'(1)) state_d = inject_q ? TAIL : DONE;
        end
      end
      TAIL: begin
        if (xfer) begin
          tail_idx_d = tail_idx_q + 3'd1;
          if (tail_idx_q == 3'd4) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // sent_q saturates at 5: only "at least five bits so far" matters for matching
    if (xfer) begin
      hist_d = {hist_q[3:0], bit_cur};
      sent_d = (sent_q >= 3'd4) ? 3'd5 : sent_q + 3'd1;
      if ((hist_d == PATTERN) && (sent_q >= 3'd4)) cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      inject_q    <= 1'b0;
      tail_idx_q  <= 3'd0;
      hist_q      <= 5'd0;
      sent_q      <= 3'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      inject_q    <= inject_d;
      tail_idx_q  <= tail_idx_d;
      hist_q      <= hist_d;
      sent_q      <= sent_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the frame register width in bits.
REQ-002 Parameter CNT_W, default 8, SHALL set the pattern counter width in bits.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk_i.
REQ-005 start_i  input  1  SHALL request transmission of one frame; sampled only in IDLE.
REQ-006 data_i  input  DATA_W  SHALL carry the frame bits, captured when start is accepted; MSB is sent first.
REQ-007 len_i  input  $clog2(DATA_W)+1  SHALL give the number of frame bits to send, 0..DATA_W, captured with data_i.
REQ-008 inject_i  input  1  SHALL request a 5-bit tail 0,1,1,0,1 (B=0, C=1, i.e. BCCBC) after the frame, captured with data_i.
REQ-009 ready_i  input  1  SHALL be downstream acceptance; a bit transfers on an edge where valid_o=1 and ready_i=1.
REQ-010 valid_o  output  1  SHALL mark d_o as a valid serial bit.
REQ-011 d_o  output  1  SHALL carry the current serial bit.
REQ-012 busy_o  output  1  SHALL be high in SEND and TAIL.
REQ-013 done_o  output  1  SHALL pulse high for exactly one cycle per completed frame.
REQ-014 pattern_cnt_o  output  CNT_W  SHALL give the number of BCCBC occurrences (overlapping) transferred in the current frame, frame bits plus tail.

Function
REQ-015 FSM states SHALL be IDLE, SEND, TAIL, DONE, one-hot encoded.
REQ-016 IDLE: start_i=1 SHALL capture data_i/len_i/inject_i, clear pattern_cnt_o and bit history, and go to SEND if len_i>0, else to TAIL if inject_i=1, else to DONE.
REQ-017 In IDLE, start_i=0 SHALL hold state; start_i SHALL be ignored in every non-IDLE state.
REQ-018 The first bit SHALL appear on d_o with valid_o=1 in the cycle after start acceptance (latency 1).
REQ-019 SEND: each transfer SHALL advance to the next bit toward the LSB; after the transfer of bit len-1, go to TAIL if inject was captured, else to DONE.
REQ-020 TAIL: SHALL send 0,1,1,0,1 in order, one bit per transfer; after the 5th transfer, go to DONE.
REQ-021 While valid_o=1 and ready_i=0, d_o and all state SHALL hold unchanged; valid_o SHALL NOT drop before the transfer.
REQ-022 valid_o SHALL be 1 only in SEND and TAIL, and 0 in IDLE and DONE.
REQ-023 DONE: done_o=1 for one cycle, then unconditionally go to IDLE; a start_i in the DONE cycle SHALL be ignored.
REQ-024 The counter SHALL keep a 5-bit history of transferred bits; on each transfer whose resulting last 5 bits (oldest first) equal 0,1,1,0,1 with at least 5 bits sent in the frame, pattern_cnt_o SHALL increment.
REQ-025 pattern_cnt_o SHALL saturate at 2^CNT_W-1 and hold its value from DONE until the next start acceptance.
REQ-026 Patterns SHALL NOT span frames; history is cleared on start acceptance.
REQ-027 len_i > DATA_W SHALL be treated as DATA_W.

Reset
REQ-028 rst_i=1 SHALL force IDLE, valid_o=0, d_o=0, busy_o=0, done_o=0, pattern_cnt_o=0, and clear history and captured registers, including mid-frame or while stalled.
REQ-029 rst_i SHALL have priority over start_i and ready_i in the same cycle.

Verification
REQ-030 data_i=16'hB400, len_i=6, inject_i=0, ready_i=1 -> d_o sequence 1,0,1,1,0,1 on 6 consecutive cycles, done_o one cycle later, pattern_cnt_o=1.
REQ-031 len_i=0, inject_i=1, ready_i=1 -> d_o 0,1,1,0,1, pattern_cnt_o=1, done_o pulses once.
REQ-032 data_i=16'h6800, len_i=8 (0,1,1,0,1,0,0,0), inject_i=1 -> tail 0,1,1,0,1 overlaps nothing extra; 13 transfers, pattern_cnt_o=2.
REQ-033 Frame 0,1,1,0,1,1,0,1 (len 8) -> overlapping detection, pattern_cnt_o=2.
REQ-034 ready_i toggled 1,0,0,1 mid-SEND -> d_o stable through the stall, no bit lost or repeated.
REQ-035 rst_i=1 during bit 3 of SEND -> next cycle valid_o=0, busy_o=0, pattern_cnt_o=0, and a following start is accepted normally.
